// File: rtl/edge_mod_pkg.sv
// edge_mod_pkg: edge-mode encoding and qualifying-edge helper for edge_mod_counter
package edge_mod_pkg;

    typedef enum logic [1:0] {
        EDGE_BOTH = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_HOLD = 2'b11
    } edge_mode_t;

    function automatic logic edge_hit(edge_mode_t mode, logic x, logic x_q);
        return mode == EDGE_BOTH ? x ^ x_q :
               mode == EDGE_RISE ? x & ~x_q :
               mode == EDGE_FALL ? ~x & x_q : 1'b0;
    endfunction

endpackage

// File: rtl/edge_mod_if.sv
// edge_mod_if: per-channel sample/control inputs and count/flag outputs of edge_mod_counter
interface edge_mod_if #(
    parameter int CH = 1,
    parameter int CW = 2
);
    import edge_mod_pkg::*;

    logic [CH-1:0]    x;
    logic [CH-1:0]    en;
    logic [CH-1:0]    clr;
    edge_mode_t       mode;
    logic [CH-1:0]    y;
    logic [CH*CW-1:0] count;
    logic [CH-1:0]    wrap;

    modport master (output x, en, clr, mode, input y, count, wrap);
    modport slave  (input x, en, clr, mode, output y, count, wrap);

endinterface

// File: rtl/edge_mod_channel.sv
// edge_mod_channel: one channel counting qualifying edges of x modulo MOD
module edge_mod_channel
    import edge_mod_pkg::*;
#(
    parameter int   MOD    = 4,
    parameter logic INIT_X = 1'b1,
    parameter int   CW     = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x,
    input  logic          en,
    input  logic          clr,
    input  edge_mode_t    mode,
    output logic          y,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic          x_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          hit, last, bad;

    // codes at or above MOD are unreachable; if ever entered they collapse to 0
    always_comb begin
        hit    = en & edge_hit(mode, x, x_q);
        last   = 32'(cnt_q) == MOD - 1;
        bad    = 32'(cnt_q) >= MOD;
        cnt_d  = (clr | bad) ? '0 : hit ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        wrap_d = ~clr & hit & last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= INIT_X;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            x_q    <= x;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign y    = cnt_q == '0;
    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/edge_mod_counter.sv
// edge_mod_counter: CH independent modulo-MOD edge counters sharing one edge mode
module edge_mod_counter #(
    parameter int   MOD    = 4,
    parameter int   CH     = 1,
    parameter logic INIT_X = 1'b1,
    parameter int   CW     = $clog2(MOD)
) (
    input logic      clk,
    input logic      rst,
    edge_mod_if.slave bus
);

    logic [CH-1:0]    y;
    logic [CH-1:0]    wrap;
    logic [CH*CW-1:0] count;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_mod_channel #(
            .MOD   (MOD),
            .INIT_X(INIT_X),
            .CW    (CW)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .x   (bus.x[i]),
            .en  (bus.en[i]),
            .clr (bus.clr[i]),
            .mode(bus.mode),
            .y   (y[i]),
            .cnt (count[i*CW +: CW]),
            .wrap(wrap[i])
        );
    end

    assign bus.y     = y;
    assign bus.wrap  = wrap;
    assign bus.count = count;

endmodule

// File: doc/edge_mod_counter.md
# edge_mod_counter

Parametrised, multi-channel Moore edge-counting state machine. Each channel samples a synchronous serial input, counts qualifying transitions modulo MOD, and raises `y` whenever the count is zero. It generalises the fixed four-state toggle-tracking FSM with the following additions:

- selectable modulus and channel count;
- edge-type modes;
- enable and synchronous clear;
- a count readout and a wrap pulse.

## Interface
- `MOD`, 4, count modulus, ≥2; states 0..MOD-1
- `CH`, 1, number of independent channels, ≥1
- `INIT_X`, 1'b1, reset value of each channel's previous-sample register
- `CW`, $clog2(MOD), derived count width; not overridden
- `clk`  in  1  clock; all sampling on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `x`  in  CH  serial inputs, already synchronous to `clk`
- `en`  in  CH  per-channel count enable
- `clr`  in  CH  per-channel synchronous clear
- `mode`  in  2  shared edge mode: 00 both, 01 rise, 10 fall, 11 hold
- `y`  out  CH  1 when the channel count == 0 (Moore, registered state)
- `count`  out  CH*CW  per-channel count; channel i at bits [i*CW +: CW]
- `wrap`  out  CH  one-cycle pulse; count just went MOD-1 → 0

## Operation
- **Per-channel state:** `x_q` (previous sample) and `cnt` (CW bits).
- **Edge detection:** rise = x & ~x_q; fall = ~x & x_q.
- **Qualifying edge by mode:**
  - 00: rise | fall
  - 01: rise only
  - 10: fall only
  - 11: none (count frozen)
- **Priority at each clock, per channel:**
  1. `clr`=1: `cnt`←0, `x_q`←x, `wrap`←0. An edge on that cycle is discarded.
  2. `en`=1 and qualifying edge: `cnt`←(cnt==MOD-1) ? 0 : cnt+1; `wrap`←(cnt==MOD-1).
  3. Otherwise `cnt` holds and `wrap`←0.
- `x_q`←x every cycle, regardless of `en`/`mode`. Edges seen while disabled are dropped and are not replayed on re-enable.
- `y` = (cnt==0), decoded from the state register only.
- A `mode` change takes effect on the next clock; it never alters `cnt`.
- Channels are fully independent; only `mode` is shared.
- With MOD=4, mode 00, INIT_X=1, the block matches the legacy four-state behaviour: `y` is high only in state 0, and x=0 in state 0 advances the count.

## Timing
- **Reset (async, immediate):** `cnt`=0, `y`=1, `wrap`=0, `count`=0, `x_q`=INIT_X.
- **Latency:** a change on `x` before clock edge k updates `count`/`y`/`wrap` immediately after edge k (1 clock).
- **`wrap`:** high for exactly the one cycle in which `count` first reads 0 after MOD-1. It is never high twice in a row unless MOD=… (impossible for MOD≥2).
- **Release from reset:** with x ≠ INIT_X, the first clock sees an edge. It counts if the mode qualifies it and `en`=1.
- **`rst` mid-count:** overrides everything; any pending `wrap` is lost.
- **Wrap-around:** MOD-1 → 0 only; `cnt` never takes values ≥ MOD. For non-power-of-two MOD, codes MOD..2^CW-1 are unreachable; if entered, the next clock forces 0.
- **Glitch/debounce:** none. An input toggling every cycle counts every cycle in mode 00.

## Structure
- Package `edge_mod_pkg`: `edge_mode_t` enum (`EDGE_BOTH`=2'b00, `EDGE_RISE`=2'b01, `EDGE_FALL`=2'b10, `EDGE_HOLD`=2'b11).
- Sub-module `edge_mod_channel`: a single channel holding `x_q`, `cnt`, `wrap`, with `MOD`/`INIT_X` parameters.
- Top: generate loop of CH `edge_mod_channel` instances plus `count` bus packing.

## Test plan
1. **Legacy equivalence.** MOD=4, CH=1, mode 00, rst then x=1 held 3 cycles → y=1, count=0. Apply x=0,1,0,1, each held 2 cycles → count 1,2,3,0. y falls after the first edge and rises after the 4th. `wrap`=1 for exactly the cycle in which count first reads 0.
2. **Rise-only.** MOD=5, mode 01, 5 full x pulses → count steps 1..4,0 on rising edges only; falls ignored. One `wrap` pulse.
3. **Clear vs edge.** Count=2, `clr`=1 in the same cycle as a rising edge (mode 00) → count=0, wrap=0. Next cycle with x stable: count stays 0 (no phantom edge).
4. **Enable and hold.** `en`=0 while x toggles 3 times → count unchanged. Then `en`=1 with x stable → no change. Mode 11 with `en`=1 and toggling → no change.
5. **Async reset and release.** Assert `rst` asynchronously at count=2, mid-cycle → y=1, count=0, wrap=0 before the next edge. Release with x=0, INIT_X=1, mode 00 → count=1 after the first clock.
6. **Channel independence.** CH=2: ch0 toggled 4 times, ch1 toggled once, `clr`[1] pulsed → count[0]=0 with wrap[0] pulse; count[1]=0, wrap[1] never asserted.
